// File: rtl/sha256_ctx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_ctx_sched_pkg
// Description : Shared defaults and width/slot helpers for the round-slot
//               scheduler of the interleaved SHA-256 core.
// Revision    : 1.0
// ============================================================================
package sha256_ctx_sched_pkg;

    localparam int c_N_CTX_DEF      = 2;
    localparam int c_N_SEQ_DEF      = 2;
    localparam int c_BLK_CYCLES_DEF = 72;
    localparam int c_CTX_OFFSET_DEF = 23;

    // Select fields never collapse to zero bits, even for a single context.
    function automatic int field_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slot_idx(input int c, input int s, input int n_seq);
        return c * n_seq + s;
    endfunction

endpackage : sha256_ctx_sched_pkg
`default_nettype wire

// File: rtl/sha256_ctx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : sha256_ctx_sched_if
// Description : Readiness/completion inputs and slot outputs of the scheduler.
// Revision    : 1.0
// ============================================================================
interface sha256_ctx_sched_if
    import sha256_ctx_sched_pkg::*;
#(
    parameter int  N_CTX      = c_N_CTX_DEF,
    parameter int  N_SEQ      = c_N_SEQ_DEF,
    parameter int  BLK_CYCLES = c_BLK_CYCLES_DEF,
    localparam int N_SLOT     = N_CTX * N_SEQ,
    localparam int P          = N_SLOT * BLK_CYCLES,
    localparam int CNT_W      = $clog2(P),
    localparam int CTX_W      = field_w(N_CTX),
    localparam int SEQ_W      = field_w(N_SEQ)
);
    logic              en;
    logic [N_SLOT-1:0] slot_ready;
    logic              blk_done;
    logic [CTX_W-1:0]  done_ctx;
    logic [SEQ_W-1:0]  done_seq;
    logic              start;
    logic [CTX_W-1:0]  start_ctx;
    logic [SEQ_W-1:0]  start_seq;
    logic [CTX_W-1:0]  ctx_num;
    logic [SEQ_W-1:0]  seq_num;
    logic [N_SLOT-1:0] busy;
    logic              skip;
    logic [CNT_W-1:0]  round_cnt;

    modport master (
        output en, slot_ready, blk_done, done_ctx, done_seq,
        input  start, start_ctx, start_seq, ctx_num, seq_num, busy, skip, round_cnt
    );

    modport slave (
        input  en, slot_ready, blk_done, done_ctx, done_seq,
        output start, start_ctx, start_seq, ctx_num, seq_num, busy, skip, round_cnt
    );
endinterface : sha256_ctx_sched_if
`default_nettype wire

// File: rtl/sha256_slot_tbl.sv
`default_nettype none
// ============================================================================
// Module      : sha256_slot_tbl
// Description : Combinational start-time match and active-sequence lookup.
// Revision    : 1.0
// ============================================================================
module sha256_slot_tbl
    import sha256_ctx_sched_pkg::*;
#(
    parameter int  N_CTX      = c_N_CTX_DEF,
    parameter int  N_SEQ      = c_N_SEQ_DEF,
    parameter int  BLK_CYCLES = c_BLK_CYCLES_DEF,
    parameter int  CTX_OFFSET = c_CTX_OFFSET_DEF,
    localparam int N_SLOT     = N_CTX * N_SEQ,
    localparam int P          = N_SLOT * BLK_CYCLES,
    localparam int CNT_W      = $clog2(P),
    localparam int CTX_W      = field_w(N_CTX),
    localparam int SEQ_W      = field_w(N_SEQ)
) (
    input  wire logic [CNT_W-1:0] cnt,
    output logic                  hit,
    output logic [CTX_W-1:0]      hit_ctx,
    output logic [SEQ_W-1:0]      hit_seq,
    output logic [SEQ_W-1:0]      seq_of
);
    localparam int c_WIN = N_CTX * BLK_CYCLES;

    logic [N_SLOT-1:0] w_match;
    logic [N_SLOT-1:0] w_inwin;

    for (genvar c = 0; c < N_CTX; c++) begin : g_ctx
        for (genvar s = 0; s < N_SEQ; s++) begin : g_seq
            localparam int c_T = (c * CTX_OFFSET + s * c_WIN) % P;
            assign w_match[c*N_SEQ+s] = (int'(cnt) == c_T);
            // Window of a sequence may straddle the counter wrap.
            assign w_inwin[c*N_SEQ+s] = (((int'(cnt) - c_T + P) % P) < c_WIN);
        end
    end

    always_comb begin
        int v_ctx;
        hit     = 1'b0;
        hit_ctx = '0;
        hit_seq = '0;
        seq_of  = '0;
        v_ctx   = int'(cnt) % N_CTX;
        for (int c = 0; c < N_CTX; c++) begin
            for (int s = 0; s < N_SEQ; s++) begin
                if (w_match[slot_idx(c, s, N_SEQ)]) begin
                    hit     = 1'b1;
                    hit_ctx = CTX_W'(c);
                    hit_seq = SEQ_W'(s);
                end
                if ((c == v_ctx) && w_inwin[slot_idx(c, s, N_SEQ)]) begin
                    seq_of = SEQ_W'(s);
                end
            end
        end
    end

endmodule : sha256_slot_tbl
`default_nettype wire

// File: rtl/sha256_ctx_sched.sv
`default_nettype none
// ============================================================================
// Module      : sha256_ctx_sched
// Description : Round counter and readiness-gated start scheduler for the
//               interleaved SHA-256 core, with in-flight slot tracking.
// Revision    : 1.0
// ============================================================================
module sha256_ctx_sched
    import sha256_ctx_sched_pkg::*;
#(
    parameter int  N_CTX      = c_N_CTX_DEF,
    parameter int  N_SEQ      = c_N_SEQ_DEF,
    parameter int  BLK_CYCLES = c_BLK_CYCLES_DEF,
    parameter int  CTX_OFFSET = c_CTX_OFFSET_DEF,
    localparam int N_SLOT     = N_CTX * N_SEQ,
    localparam int P          = N_SLOT * BLK_CYCLES,
    localparam int CNT_W      = $clog2(P),
    localparam int CTX_W      = field_w(N_CTX),
    localparam int SEQ_W      = field_w(N_SEQ)
) (
    input  wire logic         CLK,
    input  wire logic         reset,
    sha256_ctx_sched_if.slave bus
);
    if ((CTX_OFFSET % N_CTX) != 1) begin : g_chk_offset_mod
        $error("CTX_OFFSET mod N_CTX must be 1");
    end
    if ((N_CTX - 1) * CTX_OFFSET >= N_CTX * BLK_CYCLES) begin : g_chk_offset_span
        $error("(N_CTX-1)*CTX_OFFSET must be below N_CTX*BLK_CYCLES");
    end

    logic [CNT_W-1:0]  r_cnt;
    logic              r_start;
    logic [CTX_W-1:0]  r_start_ctx;
    logic [SEQ_W-1:0]  r_start_seq;
    logic [CTX_W-1:0]  r_ctx_num;
    logic [SEQ_W-1:0]  r_seq_num;
    logic [N_SLOT-1:0] r_busy;
    logic              r_skip;

    logic              w_hit;
    logic [CTX_W-1:0]  w_hit_ctx;
    logic [SEQ_W-1:0]  w_hit_seq;
    logic [SEQ_W-1:0]  w_seq_of;
    logic [CTX_W-1:0]  w_cnt_ctx;
    logic              w_done_ok;
    logic              w_go;
    logic [N_SLOT-1:0] w_clr;
    logic [N_SLOT-1:0] w_set;
    logic [N_SLOT-1:0] w_busy_nxt;

    sha256_slot_tbl #(
        .N_CTX      (N_CTX),
        .N_SEQ      (N_SEQ),
        .BLK_CYCLES (BLK_CYCLES),
        .CTX_OFFSET (CTX_OFFSET)
    ) u_slot_tbl (
        .cnt     (r_cnt),
        .hit     (w_hit),
        .hit_ctx (w_hit_ctx),
        .hit_seq (w_hit_seq),
        .seq_of  (w_seq_of)
    );

    assign w_cnt_ctx = CTX_W'(int'(r_cnt) % N_CTX);

    // A completion landing on the slot being restarted frees it in time,
    // and the set term wins over the clear in the next-state merge.
    always_comb begin
        w_clr     = '0;
        w_set     = '0;
        w_done_ok = bus.blk_done && (int'(bus.done_ctx) < N_CTX) && (int'(bus.done_seq) < N_SEQ);
        for (int i = 0; i < N_SLOT; i++) begin
            if (w_done_ok && (slot_idx(int'(bus.done_ctx), int'(bus.done_seq), N_SEQ) == i)) begin
                w_clr[i] = 1'b1;
            end
            if (bus.en && w_hit && (slot_idx(int'(w_hit_ctx), int'(w_hit_seq), N_SEQ) == i)
                && bus.slot_ready[i] && (!r_busy[i] || w_clr[i])) begin
                w_set[i] = 1'b1;
            end
        end
        w_go       = |w_set;
        w_busy_nxt = (r_busy & ~w_clr) | w_set;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cnt       <= '0;
            r_start     <= 1'b0;
            r_start_ctx <= '0;
            r_start_seq <= '0;
            r_ctx_num   <= '0;
            r_seq_num   <= '0;
            r_busy      <= '0;
            r_skip      <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_start <= w_go;
            r_skip  <= bus.en && w_hit && !w_go;
            if (w_go) begin
                r_start_ctx <= w_hit_ctx;
                r_start_seq <= w_hit_seq;
            end
            if (bus.en) begin
                r_cnt     <= (r_cnt == CNT_W'(P - 1)) ? '0 : r_cnt + 1'b1;
                r_ctx_num <= w_cnt_ctx;
                r_seq_num <= w_seq_of;
            end
        end
    end

    assign bus.start     = r_start;
    assign bus.start_ctx = r_start_ctx;
    assign bus.start_seq = r_start_seq;
    assign bus.ctx_num   = r_ctx_num;
    assign bus.seq_num   = r_seq_num;
    assign bus.busy      = r_busy;
    assign bus.skip      = r_skip;
    assign bus.round_cnt = r_cnt;

endmodule : sha256_ctx_sched
`default_nettype wire

// File: tb/tb_sha256_ctx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sha256_ctx_sched
// Description : Randomised and directed bench with a behavioural slot model.
// Revision    : 1.0
// ============================================================================
module tb_sha256_ctx_sched;
    localparam int NC  = 2;
    localparam int NS  = 2;
    localparam int BLK = 72;
    localparam int OFF = 23;
    localparam int NSL = NC * NS;
    localparam int P   = NSL * BLK;
    localparam int WIN = NC * BLK;

    logic CLK = 1'b0;
    logic reset;
    logic rst2;
    always #5 CLK = ~CLK;

    sha256_ctx_sched_if #(.N_CTX(NC), .N_SEQ(NS), .BLK_CYCLES(BLK)) bus ();
    sha256_ctx_sched #(.N_CTX(NC), .N_SEQ(NS), .BLK_CYCLES(BLK), .CTX_OFFSET(OFF)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    sha256_ctx_sched_if #(.N_CTX(4), .N_SEQ(1), .BLK_CYCLES(64)) bus2 ();
    sha256_ctx_sched #(.N_CTX(4), .N_SEQ(1), .BLK_CYCLES(64), .CTX_OFFSET(5)) dut2 (
        .CLK   (CLK),
        .reset (rst2),
        .bus   (bus2)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Model state and expected DUT outputs after the most recent edge
    int       m_cnt;
    bit [3:0] m_busy;
    int e_start, e_sctx, e_sseq, e_ctx, e_seq, e_skip;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int t_of(input int c, input int s);
        return (c * OFF + s * WIN) % P;
    endfunction

    // Reads the inputs that were applied across the edge just taken.
    task automatic model_step();
        bit [3:0] nb;
        int       didx;
        if (reset) begin
            m_cnt = 0; m_busy = '0;
            e_start = 0; e_sctx = 0; e_sseq = 0; e_ctx = 0; e_seq = 0; e_skip = 0;
            return;
        end
        nb   = m_busy;
        didx = -1;
        if (bus.blk_done) begin
            didx = int'(bus.done_ctx) * NS + int'(bus.done_seq);
            nb[didx] = 1'b0;
        end
        e_start = 0;
        e_skip  = 0;
        if (bus.en) begin
            for (int c = 0; c < NC; c++) begin
                for (int s = 0; s < NS; s++) begin
                    if (t_of(c, s) == m_cnt) begin
                        if (bus.slot_ready[c*NS+s] && (!m_busy[c*NS+s] || didx == c*NS+s)) begin
                            e_start = 1; e_sctx = c; e_sseq = s; nb[c*NS+s] = 1'b1;
                        end else begin
                            e_skip = 1;
                        end
                    end
                end
            end
            e_ctx = m_cnt % NC;
            e_seq = ((m_cnt - t_of(e_ctx, 0) + P) % P) / WIN;
            m_cnt = (m_cnt + 1) % P;
        end
        m_busy = nb;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        model_step();
    endtask

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("start",     int'(bus.start),     e_start);
            chk("start_ctx", int'(bus.start_ctx), e_sctx);
            chk("start_seq", int'(bus.start_seq), e_sseq);
            chk("ctx_num",   int'(bus.ctx_num),   e_ctx);
            chk("seq_num",   int'(bus.seq_num),   e_seq);
            chk("skip",      int'(bus.skip),      e_skip);
            chk("busy",      int'(bus.busy),      int'(m_busy));
            chk("round_cnt", int'(bus.round_cnt), m_cnt);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int q_rc[$];
        int q_cs[$];
        int n_skip, n00, dcd, seen;
        reset = 1'b1;
        bus.en = 1'b1;
        bus.slot_ready = 4'b1111;
        bus.blk_done = 1'b0;
        bus.done_ctx = '0;
        bus.done_seq = '0;
        step();
        chk_on = 1'b1;
        step();
        chk("reset_cnt",  int'(bus.round_cnt), 0);
        chk("reset_busy", int'(bus.busy), 0);
        reset = 1'b0;

        // All slots ready, no completions: four starts, then four skips
        n_skip = 0;
        for (int i = 0; i < 2 * P; i++) begin
            step();
            if (bus.start && i < P) begin
                q_rc.push_back(int'(bus.round_cnt));
                q_cs.push_back(int'(bus.start_ctx) * 2 + int'(bus.start_seq));
            end
            if (bus.start && i >= P) chk("no_start_p2", 1, 0);
            if (bus.skip && i >= P) n_skip++;
            if (i == 167) chk("busy_full_168", int'(bus.busy), 15);
        end
        chk("n_starts_p1", q_rc.size(), 4);
        if (q_rc.size() == 4) begin
            chk("start0_cnt", q_rc[0], 1);   chk("start0_slot", q_cs[0], 0);
            chk("start1_cnt", q_rc[1], 24);  chk("start1_slot", q_cs[1], 2);
            chk("start2_cnt", q_rc[2], 145); chk("start2_slot", q_cs[2], 1);
            chk("start3_cnt", q_rc[3], 168); chk("start3_slot", q_cs[3], 3);
        end
        chk("n_skips_p2", n_skip, 4);

        // Completion and restart of c0s0 on the same edge
        bus.blk_done = 1'b1;
        step();
        bus.blk_done = 1'b0;
        chk("wrap_restart", int'(bus.start), 1);
        chk("wrap_busy",    int'(bus.busy), 15);

        // c0s0 completes 72 cycles after each start and restarts every period
        do_reset();
        n00 = 0;
        dcd = -1;
        for (int i = 0; i < 3 * P; i++) begin
            step();
            bus.blk_done = 1'b0;
            if (e_start == 1 && e_sctx == 0 && e_sseq == 0) begin
                n00++;
                dcd = 71;
            end else if (dcd > 0) begin
                dcd--;
                if (dcd == 0) begin
                    bus.blk_done = 1'b1;
                    dcd = -1;
                end
            end
        end
        bus.blk_done = 1'b0;
        chk("c0s0_restarts", n00, 3);

        // c1s0 not ready on its first turn, ready on the next
        do_reset();
        bus.slot_ready = 4'b1011;
        repeat (23) step();
        step();
        chk("nr_skip",  int'(bus.skip), 1);
        chk("nr_start", int'(bus.start), 0);
        chk("nr_busy2", int'(bus.busy[2]), 0);
        bus.slot_ready = 4'b1111;
        for (int i = 0; i < P && m_cnt != 23; i++) step();
        step();
        chk("ready_start",     int'(bus.start), 1);
        chk("ready_start_ctx", int'(bus.start_ctx), 1);

        // Pause at cnt=20 for ten cycles
        do_reset();
        repeat (20) step();
        bus.en = 1'b0;
        seen = 0;
        repeat (10) begin
            step();
            seen += int'(bus.start);
        end
        chk("pause_hold_cnt", int'(bus.round_cnt), 20);
        chk("pause_no_start", seen, 0);
        bus.en = 1'b1;
        repeat (3) step();
        chk("pause_not_yet", int'(bus.start), 0);
        step();
        chk("pause_start",     int'(bus.start), 1);
        chk("pause_start_ctx", int'(bus.start_ctx), 1);

        // Random traffic, occasional reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.en         = ($urandom_range(0, 7) != 0);
            bus.slot_ready = 4'($urandom_range(0, 15));
            bus.blk_done   = ($urandom_range(0, 3) == 0);
            bus.done_ctx   = 1'($urandom_range(0, 1));
            bus.done_seq   = 1'($urandom_range(0, 1));
            reset          = ($urandom_range(0, 499) == 0);
            step();
        end
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Four-context, single-sequence configuration
    initial begin
        int q_rc[$];
        int q_ctx[$];
        rst2 = 1'b1;
        bus2.en = 1'b1;
        bus2.slot_ready = 4'b1111;
        bus2.blk_done = 1'b0;
        bus2.done_ctx = '0;
        bus2.done_seq = '0;
        repeat (2) @(posedge CLK);
        #1;
        rst2 = 1'b0;
        for (int i = 0; i < 200 && bus2.round_cnt != 8'd100; i++) begin
            @(posedge CLK);
            #1;
            if (bus2.start) begin
                q_rc.push_back(int'(bus2.round_cnt));
                q_ctx.push_back(int'(bus2.start_ctx));
            end
        end
        chk("c4_at_100", int'(bus2.round_cnt), 100);
        chk("c4_n_starts", q_rc.size(), 4);
        if (q_rc.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("c4_start_cnt", q_rc[k], 1 + 5 * k);
                chk("c4_start_ctx", q_ctx[k], k);
            end
        end
        rst2 = 1'b1;
        @(posedge CLK);
        #1;
        rst2 = 1'b0;
        chk("c4_rst_cnt",   int'(bus2.round_cnt), 0);
        chk("c4_rst_busy",  int'(bus2.busy), 0);
        chk("c4_rst_start", int'(bus2.start), 0);
        chk("c4_rst_skip",  int'(bus2.skip), 0);
        chk("c4_rst_ctx",   int'(bus2.ctx_num) + int'(bus2.start_ctx), 0);
        @(posedge CLK);
        #1;
        chk("c4_restart_cnt",   int'(bus2.round_cnt), 1);
        chk("c4_restart_start", int'(bus2.start), 1);
    end

endmodule : tb_sha256_ctx_sched
`default_nettype wire

// File: doc/sha256_ctx_sched.md
Name: sha256_ctx_sched

Overview:
- Parametrised round-slot scheduler for the interleaved sha256core.
- Owns the free-running round counter. Generates registered start / ctx_num / seq_num for N_CTX interleaved contexts × N_SEQ sequences per context, and replaces the fixed 288-cycle hand-coded sequencer.
- New behaviour over the fixed sequencer:
  - gates each start on per-slot input readiness;
  - tracks in-flight slots until the core reports completion;
  - supports pause (en) and skip reporting.

Parameters:
- N_CTX, 2, interleaved contexts; ctx slot = cnt mod N_CTX.
- N_SEQ, 2, sequences per context (time-multiplexed).
- BLK_CYCLES, 72, per-context cycles for one block (64 rounds + overhead).
- CTX_OFFSET, 23, start offset between consecutive contexts.
  - Required: CTX_OFFSET mod N_CTX == 1.
  - Required: (N_CTX-1)*CTX_OFFSET < N_CTX*BLK_CYCLES.
  - Elaboration fails if either is violated.
- Derived:
  - N_SLOT = N_CTX*N_SEQ.
  - P = N_SLOT*BLK_CYCLES (period).
  - CNT_W = $clog2(P).
  - CTX_W = max(1,$clog2(N_CTX)).
  - SEQ_W = max(1,$clog2(N_SEQ)).

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance counter when 1; hold everything when 0.
- slot_ready  in  N_SLOT  bit c*N_SEQ+s = input block for (ctx c, seq s) loaded and ready.
- blk_done  in  1  core finished a block; qualifies done_ctx/done_seq.
- done_ctx  in  CTX_W  context of the finished block.
- done_seq  in  SEQ_W  sequence of the finished block.
- start  out  1  one-cycle pulse: core begins a block in slot (start_ctx, start_seq).
- start_ctx  out  CTX_W  context of the start.
- start_seq  out  SEQ_W  sequence of the start.
- ctx_num  out  CTX_W  context owning the current core cycle.
- seq_num  out  SEQ_W  sequence active for ctx_num.
- busy  out  N_SLOT  in-flight mask.
- skip  out  1  one-cycle pulse: a start time passed without a start.
- round_cnt  out  CNT_W  current counter value (debug).

Behaviour:
- Reset: cnt=0; start=0; start_ctx=0; start_seq=0; ctx_num=0; seq_num=0; busy=0; skip=0; round_cnt=0. Reset asserted mid-block aborts all slots (busy cleared) with no further pulses.
- Counter:
  - If en, cnt <= (cnt==P-1) ? 0 : cnt+1.
  - If !en, cnt and all registered outputs hold; start and skip are forced 0.
- Slot start time: T(c,s) = (c*CTX_OFFSET + s*N_CTX*BLK_CYCLES) mod P. Defaults give 0 (c0s0), 144 (c0s1), 23 (c1s0), 167 (c1s1).
- Registered outputs, 1-cycle latency from cnt:
  - ctx_num <= cnt mod N_CTX.
  - seq_num <= s such that cnt lies in [T(c,s), T(c,s)+N_CTX*BLK_CYCLES-1] mod P, where c = cnt mod N_CTX.
- Start decision when en and cnt==T(c,s):
  - If slot_ready[c,s] and (!busy[c,s] or done-clears-same-slot this cycle): start=1, start_ctx=c, start_seq=s, busy[c,s] set next cycle.
  - Otherwise: skip=1, busy unchanged.
  - Only one T matches per cycle, so start is at most one pulse per cycle.
- Completion: blk_done clears busy[done_ctx,done_seq] next cycle, independent of en.
  - blk_done on a non-busy slot is ignored.
  - Out-of-range done_ctx/done_seq are ignored.
- Simultaneous set and clear of the same slot: the set wins, so busy stays 1 and a new block starts.
- Wrap: cnt P-1 → 0 issues the c0s0 decision at cnt=0 as normal; there is no special edge case.

Decomposition:
- Shared package/header (sha256.vh):
  - default N_CTX, N_SEQ, BLK_CYCLES, CTX_OFFSET;
  - CTX_W/SEQ_W macros;
  - slot index macro SLOT_IDX(c,s) = c*N_SEQ+s.
- One sub-module, sha256_slot_tbl: a purely combinational function of cnt producing hit, hit_ctx, hit_seq (start-time match) and seq_of(cnt). It is built from generate-time constants, so it can be reused by the output-buffer arbiter.

Test Plan:
- Defaults, slot_ready=4'b1111, blk_done never → start pulses with cnt at 0/23/144/167 (visible 1 cycle later), ctx/seq = (0,0)/(1,0)/(0,1)/(1,1). busy=4'b1111 after 168 cycles. The second period gives skip at each of the four times and no start.
- Defaults, blk_done for (0,0) 72 cycles after each start, slot_ready=1111 → c0s0 restarts at every cnt=0 across 3 periods. Check that ctx_num alternates 0,1 each cycle and seq_num for ctx0 is 0 at cnt 0..143 and 1 at cnt 144..287.
- slot_ready[2]=0 (c1s0) → at cnt=23: skip=1, start=0, busy[2]=0. Set slot_ready[2] before the next period → start at the next cnt=23.
- en=0 for 10 cycles at cnt=20 → round_cnt holds at 20, no start. After release, the c1s0 start occurs 3 enabled cycles later.
- blk_done(0,0) in the same cycle as cnt=0 with busy[0]=1, slot_ready[0]=1 → start=1 and busy[0] remains 1.
- N_CTX=4, N_SEQ=1, BLK_CYCLES=64, CTX_OFFSET=5 → P=256, starts at cnt 0,5,10,15 with ctx 0..3. Reset asserted at cnt=100 → all outputs 0 next cycle and cnt restarts from 0.
